sync_dest_split9: RTL and testbench
===================================

// Module: sync_dest_split9
// PURPOSE
//  Clocked 1-to-N destination splitter; the distribution-side counterpart of the arbitrated N-to-1 merge.
//  Accepts one word per cycle on a single drive/free channel, steers it by i_dest into a 1-entry
//  buffer per output port, and supports broadcast. Out-of-range destinations are accepted, dropped and counted.
//  Each port drains independently, so a stalled consumer never blocks traffic to other free ports.
// PARAMETERS
//  DATA_WIDTH  12  payload width in bits
//  NUM_PORTS   9   number of output ports; legal range 2..15
//  DEST_WIDTH  4   width of i_dest; the value all-ones (4'hF) means broadcast
// PORTS
//  clk          in   1                     clock; all state changes on the rising edge
//  rstn         in   1                     synchronous reset, active-low
//  i_drive      in   1                     input word valid (level)
//  i_data       in   DATA_WIDTH            input payload
//  i_dest       in   DEST_WIDTH            destination port index, or all-ones for broadcast
//  o_free       out  1                     input ready (combinational; see acceptance rule)
//  o_driveNext  out  NUM_PORTS             per-port output valid
//  o_data       out  NUM_PORTS*DATA_WIDTH  per-port payload; port k occupies [k*DATA_WIDTH +: DATA_WIDTH]
//  i_freeNext   in   NUM_PORTS             per-port consumer ready
//  o_drop       out  1                     one-cycle pulse on the cycle after a word is dropped
//  o_drop_cnt   out  8                     saturating count of dropped words
// BEHAVIOUR
//  Reset: clocked while rstn=0. Clears all valid bits, data registers, o_drop and o_drop_cnt to 0.
//   Words still pending at reset are discarded. After reset, o_free follows the acceptance rule.
//  Port state: valid[k] drives o_driveNext[k]. data[k] drives o_data slice k.
//  Output transfer: port k transfers on any edge where valid[k] and i_freeNext[k] are both 1.
//   valid[k] clears unless the same edge reloads it.
//  Port availability: avail[k] = ~valid[k] | i_freeNext[k]. This allows same-cycle drain and refill.
//  Acceptance rule, o_free (combinational from i_dest, valid and i_freeNext; it does not depend on i_drive):
//   - i_dest < NUM_PORTS: o_free = avail[i_dest]
//   - i_dest = all-ones (broadcast): o_free = AND of avail over all ports
//   - otherwise (out of range): o_free = 1
//  Input transfer: occurs when i_drive & o_free at a rising edge.
//   - unicast: valid[i_dest] <= 1 and data[i_dest] <= i_data
//   - broadcast: all valid <= 1 and all data <= i_data, in a single edge. No partial broadcast is ever performed.
//   - out of range: no port changes. o_drop=1 for the next cycle. o_drop_cnt increments and saturates at 8'hFF.
//  Latency: a word accepted at edge n is visible on o_driveNext/o_data after edge n.
//   Throughput is 1 word/cycle while targets are available.
//  Ordering: per-port FIFO order is preserved (depth 1). There is no ordering guarantee across ports.
//  Stability: o_data[k] holds while valid[k]=1 and the port has not transferred.
//   The slice is not modified by traffic to other ports.
//  If i_drive=1 while o_free=0, the input must hold i_data and i_dest stable until accepted.
//   The block takes no action and raises no error.
//  Decode: a registered 1-hot steer vector is not used; the decode of i_dest is purely combinational into per-port load enables.
//  If NUM_PORTS=15, dest 4'hF is still broadcast. No index maps to a 16th port.
// TESTING
//  1 Reset: hold rstn=0 for 3 cycles with i_drive=1.
//    -> o_driveNext=0, o_data=0, o_drop_cnt=0. No acceptance. o_free=1 after release for dest 0.
//  2 Unicast: i_dest=3, i_data=12'hA5C for 1 cycle, i_freeNext=all 1s.
//    -> o_driveNext=9'b000001000 for exactly 1 cycle after the edge, with slice 3 = 12'hA5C.
//  3 Backpressure/refill: i_freeNext[5]=0, send 12'h111 then 12'h222 to port 5.
//    -> o_free=0 on the 2nd word. Raise i_freeNext[5]: 12'h111 transfers and 12'h222 loads on the same edge.
//  4 Broadcast: valid[2]=1 held (i_freeNext[2]=0), i_dest=4'hF, data 12'h0F0.
//    -> o_free=0 and no port loads. Release port 2: all 9 ports load 12'h0F0 on one edge.
//  5 Drops: send 300 words with i_dest=4'd9.
//    -> 300 o_drop pulses. o_drop_cnt saturates at 8'hFF. No o_driveNext activity.
//  6 Mid-operation reset: ports 0, 4 and 8 full and stalled, assert rstn=0 for 1 cycle.
//    -> all valid clear next cycle. o_drop_cnt=0. A unicast to port 4 is accepted on the next cycle.

Source files
------------

// File: rtl/sync_dest_split9.sv
// 1-to-N destination splitter: one input word per cycle is steered by i_dest into a
// 1-entry buffer per output port, with broadcast and counted drop of out-of-range words.
module sync_dest_split9 #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned NUM_PORTS  = 9,
    parameter int unsigned DEST_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            i_drive,
    input  logic [DATA_WIDTH-1:0]           i_data,
    input  logic [DEST_WIDTH-1:0]           i_dest,
    output logic                            o_free,
    output logic [NUM_PORTS-1:0]            o_driveNext,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] o_data,
    input  logic [NUM_PORTS-1:0]            i_freeNext,
    output logic                            o_drop,
    output logic [7:0]                      o_drop_cnt
);

    localparam logic [DEST_WIDTH-1:0] DestBcast   = '1;
    localparam logic [DEST_WIDTH-1:0] NumPortsDst = DEST_WIDTH'(NUM_PORTS);

    logic [NUM_PORTS-1:0]  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0] data_d [NUM_PORTS];
    logic                  drop_q, drop_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic                  dest_bcast;
    logic                  dest_hit;
    logic [NUM_PORTS-1:0]  dest_onehot;
    logic [NUM_PORTS-1:0]  avail;
    logic [NUM_PORTS-1:0]  load_en;
    logic                  accept;

    // Purely combinational decode; all-ones is broadcast even when NUM_PORTS is 15.
    always_comb begin
        dest_bcast  = (i_dest == DestBcast);
        dest_hit    = !dest_bcast && (i_dest < NumPortsDst);
        dest_onehot = '0;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            dest_onehot[k] = dest_hit && (i_dest == DEST_WIDTH'(k));
        end
    end

    // A port may be refilled on the same edge that drains it.
    assign avail = ~valid_q | i_freeNext;

    always_comb begin
        if (dest_bcast) begin
            o_free = &avail;
        end else if (dest_hit) begin
            o_free = |(dest_onehot & avail);
        end else begin
            o_free = 1'b1;
        end
    end

    assign accept = i_drive & o_free;

    always_comb begin
        load_en = '0;
        if (accept) begin
            load_en = dest_bcast ? {NUM_PORTS{1'b1}} : dest_onehot;
        end
    end

    always_comb begin
        valid_d = load_en | (valid_q & ~i_freeNext);
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            data_d[k] = load_en[k] ? i_data : data_q[k];
        end
    end

    always_comb begin
        drop_d     = accept && !dest_bcast && !dest_hit;
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q    <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            for (int k = 0; k < int'(NUM_PORTS); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            for (int k = 0; k < int'(NUM_PORTS); k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign o_driveNext = valid_q;
    assign o_drop      = drop_q;
    assign o_drop_cnt  = drop_cnt_q;

    for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_port_data
        assign o_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
    end

endmodule

// File: tb/tb_sync_dest_split9.sv
// Directed bench for sync_dest_split9: reset, unicast, backpressure/refill, broadcast,
// saturating drops and mid-operation reset, all against hand-computed expectations.
module tb_sync_dest_split9;

    localparam int unsigned DW = 12;
    localparam int unsigned NP = 9;
    localparam int unsigned TW = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              i_drive;
    logic [DW-1:0]     i_data;
    logic [TW-1:0]     i_dest;
    logic              o_free;
    logic [NP-1:0]     o_driveNext;
    logic [NP*DW-1:0]  o_data;
    logic [NP-1:0]     i_freeNext;
    logic              o_drop;
    logic [7:0]        o_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NP*DW-1:0] exp_vec;

    always #5 clk = ~clk;

    sync_dest_split9 #(
        .DATA_WIDTH(DW),
        .NUM_PORTS (NP),
        .DEST_WIDTH(TW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_drive    (i_drive),
        .i_data     (i_data),
        .i_dest     (i_dest),
        .o_free     (o_free),
        .o_driveNext(o_driveNext),
        .o_data     (o_data),
        .i_freeNext (i_freeNext),
        .o_drop     (o_drop),
        .o_drop_cnt (o_drop_cnt)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int drop_pulses;
    int drive_seen;

    initial begin
        rstn       = 1'b0;
        i_drive    = 1'b1;
        i_data     = 12'h123;
        i_dest     = 4'd0;
        i_freeNext = '1;
        exp_vec    = '0;

        // 1: reset held for 3 cycles with i_drive high
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_valid", o_driveNext, 9'b0);
            check_eq("rst_data", o_data, exp_vec);
            check_eq("rst_cnt", o_drop_cnt, 8'h00);
        end
        i_drive = 1'b0;
        rstn    = 1'b1;
        #1;
        check_eq("rst_free_dest0", o_free, 1'b1);
        tick();
        check_eq("post_rst_valid", o_driveNext, 9'b0);

        // 2: unicast to port 3
        i_drive = 1'b1;
        i_dest  = 4'd3;
        i_data  = 12'hA5C;
        #1;
        check_eq("uni_free", o_free, 1'b1);
        tick();
        i_drive = 1'b0;
        exp_vec[3*DW +: DW] = 12'hA5C;
        check_eq("uni_valid", o_driveNext, 9'b000001000);
        check_eq("uni_data", o_data, exp_vec);
        tick();
        check_eq("uni_drained", o_driveNext, 9'b0);

        // 3: backpressure and same-edge drain/refill on port 5
        i_freeNext = 9'b111011111;
        i_drive    = 1'b1;
        i_dest     = 4'd5;
        i_data     = 12'h111;
        #1;
        check_eq("bp_free1", o_free, 1'b1);
        tick();
        exp_vec[5*DW +: DW] = 12'h111;
        check_eq("bp_valid1", o_driveNext, 9'b000100000);
        i_data = 12'h222;
        #1;
        check_eq("bp_free2_blocked", o_free, 1'b0);
        tick();
        check_eq("bp_hold_data", o_data, exp_vec);
        check_eq("bp_hold_valid", o_driveNext, 9'b000100000);
        i_freeNext = '1;
        #1;
        check_eq("bp_free_refill", o_free, 1'b1);
        tick();
        i_drive = 1'b0;
        exp_vec[5*DW +: DW] = 12'h222;
        check_eq("bp_refill_valid", o_driveNext, 9'b000100000);
        check_eq("bp_refill_data", o_data, exp_vec);
        tick();
        check_eq("bp_drained", o_driveNext, 9'b0);

        // 4: broadcast blocked by stalled port 2, then all ports load together
        i_freeNext = 9'b111111011;
        i_drive    = 1'b1;
        i_dest     = 4'd2;
        i_data     = 12'h2AA;
        tick();
        exp_vec[2*DW +: DW] = 12'h2AA;
        i_dest = 4'hF;
        i_data = 12'h0F0;
        #1;
        check_eq("bc_blocked_free", o_free, 1'b0);
        tick();
        check_eq("bc_no_load_valid", o_driveNext, 9'b000000100);
        check_eq("bc_no_load_data", o_data, exp_vec);
        i_freeNext = '1;
        #1;
        check_eq("bc_free", o_free, 1'b1);
        tick();
        i_drive = 1'b0;
        exp_vec = {NP{12'h0F0}};
        check_eq("bc_valid", o_driveNext, 9'h1FF);
        check_eq("bc_data", o_data, exp_vec);
        tick();
        check_eq("bc_drained", o_driveNext, 9'b0);

        // 5: 300 out-of-range words
        i_drive     = 1'b1;
        i_dest      = 4'd9;
        i_data      = 12'h999;
        drop_pulses = 0;
        drive_seen  = 0;
        #1;
        check_eq("drop_free", o_free, 1'b1);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (o_drop === 1'b1) drop_pulses++;
            if (o_driveNext !== 9'b0) drive_seen++;
            if (i == 0) check_eq("drop_cnt_first", o_drop_cnt, 8'h01);
        end
        i_drive = 1'b0;
        check_eq("drop_pulses", drop_pulses, 300);
        check_eq("drop_no_drive", drive_seen, 0);
        check_eq("drop_cnt_sat", o_drop_cnt, 8'hFF);
        check_eq("drop_data_kept", o_data, exp_vec);
        tick();
        check_eq("drop_pulse_end", o_drop, 1'b0);
        check_eq("drop_cnt_hold", o_drop_cnt, 8'hFF);

        // 6: reset while ports 0, 4 and 8 are full and stalled
        i_freeNext = 9'b011101110;
        i_drive    = 1'b1;
        i_dest     = 4'd0;
        i_data     = 12'h100;
        tick();
        i_dest = 4'd4;
        i_data = 12'h104;
        tick();
        i_dest = 4'd8;
        i_data = 12'h108;
        tick();
        i_drive = 1'b0;
        check_eq("mid_full", o_driveNext, 9'b100010001);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        exp_vec = '0;
        check_eq("mid_rst_valid", o_driveNext, 9'b0);
        check_eq("mid_rst_cnt", o_drop_cnt, 8'h00);
        check_eq("mid_rst_data", o_data, exp_vec);
        i_drive = 1'b1;
        i_dest  = 4'd4;
        i_data  = 12'h444;
        #1;
        check_eq("mid_free4", o_free, 1'b1);
        tick();
        i_drive = 1'b0;
        exp_vec[4*DW +: DW] = 12'h444;
        check_eq("mid_uni_valid", o_driveNext, 9'b000010000);
        check_eq("mid_uni_data", o_data, exp_vec);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
